// File: rtl/serial_parity_checker_pkg.sv
// rtl/serial_parity_checker_pkg.sv - shared encodings for the serial parity unit
// Purpose: parity mode and FSM state encodings shared by the Rx checker and the
//          Tx parity generator.
// Ports:   none (package)
package serial_parity_checker_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/serial_parity_checker_mode_sel.sv
// rtl/serial_parity_checker_mode_sel.sv - accumulated parity + mode -> parity bit
// Purpose: combinational selection of the parity bit for a frame given the
//          running XOR of its data bits and the parity mode.
// Ports:   acc    in  1  XOR of all data bits so far
//          mode   in  2  parity mode (even/odd/mark/space)
//          parity out 1  parity bit expected on the line
module parity_mode_sel
    import serial_parity_checker_pkg::*;
(
    input  logic       acc,
    input  logic [1:0] mode,
    output logic       parity
);

    always_comb begin
        parity = 1'b0;
        case (mode)
            PAR_EVEN:  parity = acc;
            PAR_ODD:   parity = ~acc;
            PAR_MARK:  parity = 1'b1;
            PAR_SPACE: parity = 1'b0;
            default:   parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial parity accumulation and check for UART Rx
// Purpose: assembles an LSB-first data word from sampled bits, accumulates its
//          parity, and compares the received parity bit under the frame's mode.
// Ports:   clk          in  1          rising-edge clock
//          reset        in  1          asynchronous active-high reset
//          frame_start  in  1          opens a frame, samples parity_mode
//          parity_mode  in  2          parity mode for the next frame
//          bit_valid    in  1          bit_in holds a sampled bit
//          bit_in       in  1          sampled serial bit
//          busy         out 1          frame in progress (DATA or PARITY)
//          data_out     out DATA_BITS  assembled word, held until next frame_start
//          parity_calc  out 1          expected parity for data_out
//          done         out 1          one-cycle result strobe
//          parity_err   out 1          received parity mismatched parity_calc
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [1:0]           parity_mode,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_calc,
    output logic                 done,
    output logic                 parity_err
);

    localparam int CW = $clog2(DATA_BITS + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          acc_nxt;
    logic [1:0]    mode_q;
    logic [1:0]    mode_nxt;
    logic          parity_nxt;

    // parity_calc is registered from the next-state acc/mode so it is already
    // correct when a parity strobe follows the last data strobe back-to-back.
    always_comb begin
        acc_nxt  = acc;
        mode_nxt = mode_q;
        if (frame_start) begin
            acc_nxt  = 1'b0;
            mode_nxt = parity_mode;
        end else if (state == ST_DATA && bit_valid) begin
            acc_nxt = acc ^ bit_in;
        end
    end

    parity_mode_sel u_mode_sel (
        .acc    (acc_nxt),
        .mode   (mode_nxt),
        .parity (parity_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= 1'b0;
            mode_q      <= PAR_EVEN;
            busy        <= 1'b0;
            data_out    <= '0;
            parity_calc <= 1'b0;
            done        <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            done        <= 1'b0;
            acc         <= acc_nxt;
            mode_q      <= mode_nxt;
            parity_calc <= parity_nxt;
            // frame_start outranks everything: it aborts a frame in flight and
            // drops any bit strobed in the same cycle.
            if (frame_start) begin
                state      <= ST_DATA;
                busy       <= 1'b1;
                cnt        <= '0;
                data_out   <= '0;
                parity_err <= 1'b0;
            end else begin
                case (state)
                    ST_DATA: begin
                        if (bit_valid) begin
                            data_out <= {bit_in, data_out[DATA_BITS-1:1]};
                            cnt      <= cnt + 1'b1;
                            if (cnt == CW'(DATA_BITS - 1)) begin
                                state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_valid) begin
                            done       <= 1'b1;
                            parity_err <= (bit_in != parity_calc);
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - bench for serial_parity_checker at 5, 8 and 9 data bits
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [1:0] parity_mode;
    logic       bit_valid;
    logic       bit_in;

    logic       busy5, pcalc5, done5, err5;
    logic [4:0] data5;
    logic       busy8, pcalc8, done8, err8;
    logic [7:0] data8;
    logic       busy9, pcalc9, done9, err9;
    logic [8:0] data9;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_BITS(5)) dut5 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .parity_mode(parity_mode),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy5), .data_out(data5),
        .parity_calc(pcalc5), .done(done5), .parity_err(err5));

    serial_parity_checker #(.DATA_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .parity_mode(parity_mode),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy8), .data_out(data8),
        .parity_calc(pcalc8), .done(done8), .parity_err(err8));

    serial_parity_checker #(.DATA_BITS(9)) dut9 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .parity_mode(parity_mode),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy9), .data_out(data9),
        .parity_calc(pcalc9), .done(done9), .parity_err(err9));

    // Observe the instance under test through one set of signals.
    int         sel = 8;
    logic       o_busy, o_pcalc, o_done, o_err;
    logic [8:0] o_data;

    always_comb begin
        o_busy  = busy8;
        o_pcalc = pcalc8;
        o_done  = done8;
        o_err   = err8;
        o_data  = {1'b0, data8};
        if (sel == 5) begin
            o_busy  = busy5;
            o_pcalc = pcalc5;
            o_done  = done5;
            o_err   = err5;
            o_data  = {4'b0, data5};
        end else if (sel == 9) begin
            o_busy  = busy9;
            o_pcalc = pcalc9;
            o_done  = done9;
            o_err   = err9;
            o_data  = data9;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done should be high.
    task automatic send_frame(input string name, input logic [1:0] mode, input logic [8:0] data,
                              input int nb, input logic pbit, input bit coin, input bit tog,
                              input logic [8:0] exp_data, input logic exp_pcalc,
                              input logic exp_err);
        int stray = 0;
        frame_start = 1'b1;
        parity_mode = mode;
        bit_valid   = coin;
        bit_in      = coin;
        @(negedge clk);
        frame_start = 1'b0;
        check({name, " busy_start"}, {8'b0, o_busy}, 9'd1);
        for (int i = 0; i < nb; i++) begin
            if (o_done) stray++;
            bit_valid = 1'b1;
            bit_in    = data[i];
            if (tog) parity_mode = ~parity_mode;
            @(negedge clk);
        end
        if (o_done) stray++;
        bit_in = pbit;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check({name, " stray_done"}, 9'(stray), 9'd0);
        check({name, " done"},       {8'b0, o_done},  9'd1);
        check({name, " busy_end"},   {8'b0, o_busy},  9'd0);
        check({name, " data"},       o_data,          exp_data);
        check({name, " pcalc"},      {8'b0, o_pcalc}, {8'b0, exp_pcalc});
        check({name, " perr"},       {8'b0, o_err},   {8'b0, exp_err});
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic       pbit;
        logic       exp_pcalc;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{2'b00, 8'hA5, 1'b0, 1'b0, 1'b0}; // even, 4 ones
        vecs[1] = '{2'b01, 8'h07, 1'b1, 1'b0, 1'b1}; // odd, 3 ones, wrong bit
        vecs[2] = '{2'b01, 8'h07, 1'b0, 1'b0, 1'b0}; // odd, 3 ones, right bit
        vecs[3] = '{2'b10, 8'h00, 1'b1, 1'b1, 1'b0}; // mark
        vecs[4] = '{2'b10, 8'hFF, 1'b0, 1'b1, 1'b1}; // mark, wrong bit
        vecs[5] = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b0}; // space
        vecs[6] = '{2'b11, 8'hFF, 1'b1, 1'b0, 1'b1}; // space, wrong bit
        vecs[7] = '{2'b00, 8'h01, 1'b1, 1'b1, 1'b0}; // even, 1 one
        vecs[8] = '{2'b01, 8'h00, 1'b0, 1'b1, 1'b1}; // odd, 0 ones, wrong bit

        reset       = 1'b1;
        frame_start = 1'b0;
        parity_mode = 2'b00;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy",  {8'b0, o_busy},  9'd0);
        check("reset data",  o_data,          9'd0);
        check("reset pcalc", {8'b0, o_pcalc}, 9'd0);
        check("reset done",  {8'b0, o_done},  9'd0);
        check("reset perr",  {8'b0, o_err},   9'd0);
        reset = 1'b0;
        @(negedge clk);

        // Frames run back-to-back, so each frame_start lands on the previous done cycle.
        sel = 8;
        for (int v = 0; v < 9; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].mode, {1'b0, vecs[v].data}, 8,
                       vecs[v].pbit, 1'b0, 1'b0, {1'b0, vecs[v].data},
                       vecs[v].exp_pcalc, vecs[v].exp_err);
        end
        @(negedge clk);
        check("done one cycle", {8'b0, o_done}, 9'd0);

        // Abort after 4 of 8 bits, then a clean 0x3C frame.
        frame_start = 1'b1;
        parity_mode = 2'b00;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        check("abort no done", {8'b0, o_done}, 9'd0);
        send_frame("abort", 2'b00, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0);
        @(negedge clk);

        // Reset asserted between clock edges in the middle of DATA.
        frame_start = 1'b1;
        parity_mode = 2'b01;
        @(negedge clk);
        frame_start = 1'b0;
        bit_valid   = 1'b1;
        bit_in      = 1'b1;
        repeat (2) @(negedge clk);
        bit_valid = 1'b0;
        check("mid busy",  {8'b0, o_busy},  9'd1);
        check("mid data",  o_data,          9'h0C0);
        check("mid pcalc", {8'b0, o_pcalc}, 9'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async busy",  {8'b0, o_busy},  9'd0);
        check("async data",  o_data,          9'd0);
        check("async pcalc", {8'b0, o_pcalc}, 9'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (o_done || o_busy) seen++;
            end
            bit_valid = 1'b0;
            bit_in    = 1'b0;
            check("idle strobes ignored", 9'(seen), 9'd0);
            check("idle data", o_data, 9'd0);
        end

        // Narrow and wide words: coincident strobe dropped, mode toggles mid-frame.
        sel = 5;
        send_frame("w5 odd",  2'b01, 9'h00D, 5, 1'b0, 1'b1, 1'b1, 9'h00D, 1'b0, 1'b0);
        send_frame("w5 mark", 2'b10, 9'h01F, 5, 1'b1, 1'b1, 1'b1, 9'h01F, 1'b1, 1'b0);
        sel = 9;
        send_frame("w9 even",  2'b00, 9'h1A5, 9, 1'b1, 1'b1, 1'b1, 9'h1A5, 1'b1, 1'b0);
        send_frame("w9 space", 2'b11, 9'h100, 9, 1'b1, 1'b1, 1'b0, 9'h100, 1'b0, 1'b1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
